mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//   Shares one single-ported unified memory between the IF fetch port and the MEM-stage data port.
//   Arbitration gives the data port priority, with an anti-starvation override for IF.
//   Handles one outstanding transaction at a time and holds the memory request until mem_ack.
//   Per-transaction timeout returns an error instead of hanging the pipeline.
//   Sits between the core's fetch/load-store logic and the shared memory model.
// PARAMETERS
//   ADDR_W        32   address width, all ports
//   DATA_W        32   data width, all ports
//   STARVE_LIMIT  4    consecutive data grants allowed while if_req is pending before IF is forced
//   TIMEOUT       16   max cycles mem_req may stay high without mem_ack before abort
// PORTS
//   clock      in   1        single clock, rising edge
//   reset      in   1        asynchronous, active-low reset
//   if_req     in   1        fetch request; held with if_addr stable until if_gnt
//   if_addr    in   ADDR_W   fetch byte address
//   if_gnt     out  1        fetch request accepted (combinational, this cycle)
//   if_rvalid  out  1        one-cycle pulse: fetch complete, if_rdata/if_err valid
//   if_rdata   out  DATA_W   fetched word
//   if_err     out  1        fetch timed out (valid with if_rvalid)
//   d_req      in   1        data request; d_we/d_addr/d_wdata/d_wstrb stable until d_gnt
//   d_we       in   1        1=store, 0=load
//   d_addr     in   ADDR_W   data byte address (passed through unchecked)
//   d_wdata    in   DATA_W   store data
//   d_wstrb    in   DATA_W/8 store byte enables
//   d_gnt      out  1        data request accepted (combinational, this cycle)
//   d_rvalid   out  1        one-cycle pulse: load data valid or store done
//   d_rdata    out  DATA_W   load word; 0 for stores
//   d_err      out  1        data access timed out (valid with d_rvalid)
//   mem_req    out  1        memory request; held high until mem_ack or timeout
//   mem_we/mem_addr/mem_wdata/mem_wstrb  out  per d_*  registered copy of the granted request
//   mem_ack    in   1        one-cycle pulse: access done, mem_rdata valid
//   mem_rdata  in   DATA_W   memory read data
// BEHAVIOUR
//   Reset: all outputs 0, state IDLE, starve_cnt 0, timer 0. Assertion mid-transaction
//   abandons it immediately: no rvalid is issued, and the memory must tolerate mem_req
//   dropping. if_gnt/d_gnt are forced 0 while reset is low.
//   FSM states: IDLE, BUSY_IF, BUSY_D.
//   IDLE, arbitration (combinational):
//     - d_req && !(if_req && starve_cnt==STARVE_LIMIT): d_gnt=1.
//     - else if if_req: if_gnt=1.
//     - On the grant edge: latch request into mem_* registers, mem_req<=1, go to BUSY_IF/BUSY_D.
//   BUSY_x, gnts 0, mem_req held:
//     - mem_ack: mem_req<=0, x_rvalid<=1, x_rdata<=mem_rdata (0 if store), x_err<=0, go IDLE.
//     - timer==TIMEOUT-1 without ack: mem_req<=0, x_rvalid<=1, x_rdata<=0, x_err<=1, go IDLE.
//   Latency: gnt cycle 0, mem_req high from cycle 1. mem_ack in cycle k gives rvalid in
//   cycle k+1. The next gnt is possible in cycle k+1, so back-to-back throughput is one
//   access per k+1 cycles.
//   Timeout timer: cleared on each grant; increments each BUSY cycle; saturates (no wrap).
//   starve_cnt:
//     - +1 on d_gnt while if_req is high.
//     - Cleared on if_gnt, or on d_gnt while if_req is low.
//     - Saturates at STARVE_LIMIT.
//   mem_ack while IDLE (spurious): ignored, no rvalid.
//   rvalid, err and rdata are registered pulses, each one cycle wide. rdata holds its last
//   value otherwise.
//   Simultaneous if_req and d_req with starve_cnt<STARVE_LIMIT: data wins; IF stays pending.
//   Deasserting a req before its gnt is legal; the request is simply withdrawn.
// TESTING
//   1. if_req only, addr 0x10, mem_ack 2 cycles after mem_req
//      -> if_gnt@0, mem_req@1-2, if_rvalid@3 with rdata=mem_rdata, err=0.
//   2. if_req and d_req (load 0x20) together -> d_gnt first, then if_gnt in the cycle d_rvalid pulses.
//   3. d_req held continuously with if_req pending, STARVE_LIMIT=4
//      -> exactly 4 d_gnts, then if_gnt, then starve_cnt=0.
//   4. Store 0xDEADBEEF, wstrb=4'b0011 -> mem_wdata/mem_wstrb match;
//      d_rvalid with d_rdata=0 one cycle after mem_ack.
//   5. mem_ack never asserted, TIMEOUT=16 -> mem_req high 16 cycles, then d_rvalid=1 with
//      d_err=1; next request is granted normally.
//   6. reset low for 1 cycle in BUSY_D -> all outputs 0 at once, no d_rvalid;
//      after release, if_req is granted from IDLE.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Shared-memory arbiter bus: IF fetch port, MEM data port and memory port.
// The arbiter sits on the slave side; requesters and memory sit on master.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                if_req;
  logic [ADDR_W-1:0]   if_addr;
  logic                if_gnt;
  logic                if_rvalid;
  logic [DATA_W-1:0]   if_rdata;
  logic                if_err;

  logic                d_req;
  logic                d_we;
  logic [ADDR_W-1:0]   d_addr;
  logic [DATA_W-1:0]   d_wdata;
  logic [DATA_W/8-1:0] d_wstrb;
  logic                d_gnt;
  logic                d_rvalid;
  logic [DATA_W-1:0]   d_rdata;
  logic                d_err;

  logic                mem_req;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W/8-1:0] mem_wstrb;
  logic                mem_ack;
  logic [DATA_W-1:0]   mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata, if_err,
    input  d_req, d_we, d_addr, d_wdata, d_wstrb,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ack, mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata, if_err,
    output d_req, d_we, d_addr, d_wdata, d_wstrb,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: data port first, IF forced after a run of
// data grants, one outstanding access, per-access timeout with error.
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 16
) (
  input logic          i_clk,
  input logic          i_rst_n,
  mem_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int BW = DATA_W / 8;
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] TIME_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY_IF,
    S_BUSY_D
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [SW-1:0]     r_starve;
  logic [TW-1:0]     r_timer;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [BW-1:0]     r_mem_wstrb;
  logic              r_if_rvalid;
  logic              r_if_err;
  logic [DATA_W-1:0] r_if_rdata;
  logic              r_d_rvalid;
  logic              r_d_err;
  logic [DATA_W-1:0] r_d_rdata;

  logic w_force_if;
  logic w_if_gnt;
  logic w_d_gnt;
  logic w_ack;
  logic w_tout;
  logic w_done;

  assign w_force_if = bus.if_req && (r_starve == STARVE_MAX);
  assign w_done     = w_ack || w_tout;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Grants are qualified by reset so nothing is accepted while it is low.
  always_comb begin
    w_next   = r_state;
    w_if_gnt = 1'b0;
    w_d_gnt  = 1'b0;
    w_ack    = 1'b0;
    w_tout   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.d_req && !w_force_if) begin
          w_d_gnt = i_rst_n;
          w_next  = S_BUSY_D;
        end else if (bus.if_req) begin
          w_if_gnt = i_rst_n;
          w_next   = S_BUSY_IF;
        end
      end
      S_BUSY_IF, S_BUSY_D: begin
        if (bus.mem_ack) begin
          w_ack  = 1'b1;
          w_next = S_IDLE;
        end else if (r_timer == TIME_LAST) begin
          w_tout = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_starve    <= '0;
      r_timer     <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
      r_if_rvalid <= 1'b0;
      r_if_err    <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rvalid  <= 1'b0;
      r_d_err     <= 1'b0;
      r_d_rdata   <= '0;
    end else begin
      r_if_rvalid <= 1'b0;
      r_if_err    <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_d_err     <= 1'b0;

      if (w_d_gnt || w_if_gnt) begin
        r_mem_req   <= 1'b1;
        r_timer     <= '0;
        r_mem_we    <= w_d_gnt && bus.d_we;
        r_mem_addr  <= w_d_gnt ? bus.d_addr : bus.if_addr;
        r_mem_wdata <= w_d_gnt ? bus.d_wdata : '0;
        r_mem_wstrb <= w_d_gnt ? bus.d_wstrb : '0;
      end else if (w_done) begin
        r_mem_req <= 1'b0;
      end else if (r_state != S_IDLE && r_timer != TIME_LAST) begin
        r_timer <= r_timer + 1'b1;
      end

      if (w_done && r_state == S_BUSY_IF) begin
        r_if_rvalid <= 1'b1;
        r_if_err    <= w_tout;
        r_if_rdata  <= w_ack ? bus.mem_rdata : '0;
      end

      if (w_done && r_state == S_BUSY_D) begin
        r_d_rvalid <= 1'b1;
        r_d_err    <= w_tout;
        r_d_rdata  <= (w_ack && !r_mem_we) ? bus.mem_rdata : '0;
      end

      if (w_if_gnt) begin
        r_starve <= '0;
      end else if (w_d_gnt) begin
        if (!bus.if_req)
          r_starve <= '0;
        else if (r_starve != STARVE_MAX)
          r_starve <= r_starve + 1'b1;
      end
    end
  end

  assign bus.if_gnt    = w_if_gnt;
  assign bus.d_gnt     = w_d_gnt;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_wstrb = r_mem_wstrb;
  assign bus.if_rvalid = r_if_rvalid;
  assign bus.if_err    = r_if_err;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.d_rvalid  = r_d_rvalid;
  assign bus.d_err     = r_d_err;
  assign bus.d_rdata   = r_d_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Random requesters and memory against a cycle-level transaction model,
// plus directed reset checks.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SL = 4;
  localparam int TO = 16;
  localparam int OWN_NONE = 0;
  localparam int OWN_IF   = 1;
  localparam int OWN_D    = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL), .TIMEOUT(TO)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .bus(bus)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // model of the arbiter: who owns the memory and for how long
  int own, age, starve, ack_cd;
  int if_rate, d_rate;
  bit last_ig, last_dg;
  logic          e_mem_req, e_mem_we;
  logic [AW-1:0] e_mem_addr;
  logic [DW-1:0] e_mem_wdata;
  logic [3:0]    e_mem_wstrb;
  logic          e_if_rv, e_if_err, e_d_rv, e_d_err;
  logic [DW-1:0] e_if_rdata, e_d_rdata;

  task automatic model_reset();
    own = OWN_NONE; age = 0; starve = 0; ack_cd = 0;
    last_ig = 0; last_dg = 0;
    e_mem_req = 0; e_mem_we = 0; e_mem_addr = '0;
    e_mem_wdata = '0; e_mem_wstrb = '0;
    e_if_rv = 0; e_if_err = 0; e_if_rdata = '0;
    e_d_rv = 0; e_d_err = 0; e_d_rdata = '0;
  endtask

  task automatic zero_check(input string tag);
    chk({tag, "_if_gnt"}, bus.if_gnt, 0);
    chk({tag, "_d_gnt"}, bus.d_gnt, 0);
    chk({tag, "_mem_req"}, bus.mem_req, 0);
    chk({tag, "_mem_we"}, bus.mem_we, 0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    chk({tag, "_mem_wstrb"}, bus.mem_wstrb, 0);
    chk({tag, "_if_rvalid"}, bus.if_rvalid, 0);
    chk({tag, "_if_rdata"}, bus.if_rdata, 0);
    chk({tag, "_if_err"}, bus.if_err, 0);
    chk({tag, "_d_rvalid"}, bus.d_rvalid, 0);
    chk({tag, "_d_rdata"}, bus.d_rdata, 0);
    chk({tag, "_d_err"}, bus.d_err, 0);
  endtask

  task automatic drive();
    if (bus.if_req && !last_ig) begin
      if ($urandom_range(0, 19) == 0) bus.if_req = 1'b0;
    end else begin
      bus.if_req  = ($urandom_range(0, 99) < if_rate);
      bus.if_addr = $urandom & 32'hFFFF_FFFC;
    end
    if (bus.d_req && !last_dg) begin
      if ($urandom_range(0, 19) == 0) bus.d_req = 1'b0;
    end else begin
      bus.d_req   = ($urandom_range(0, 99) < d_rate);
      bus.d_we    = $urandom_range(0, 1) == 1;
      bus.d_addr  = $urandom;
      bus.d_wdata = $urandom;
      bus.d_wstrb = 4'($urandom_range(0, 15));
    end
    bus.mem_rdata = $urandom;
    if (own != OWN_NONE) begin
      ack_cd--;
      bus.mem_ack = (ack_cd == 0);
    end else begin
      bus.mem_ack = ($urandom_range(0, 9) == 0);
    end
  endtask

  task automatic check_and_model();
    bit dg, ig, ack;
    dg = (own == OWN_NONE) && bus.d_req && !(bus.if_req && starve == SL);
    ig = (own == OWN_NONE) && !dg && bus.if_req;
    ack = bus.mem_ack;
    chk("if_gnt", bus.if_gnt, ig);
    chk("d_gnt", bus.d_gnt, dg);
    chk("mem_req", bus.mem_req, e_mem_req);
    if (e_mem_req) begin
      chk("mem_addr", bus.mem_addr, e_mem_addr);
      chk("mem_we", bus.mem_we, e_mem_we);
      if (e_mem_we) begin
        chk("mem_wdata", bus.mem_wdata, e_mem_wdata);
        chk("mem_wstrb", bus.mem_wstrb, e_mem_wstrb);
      end
    end
    chk("if_rvalid", bus.if_rvalid, e_if_rv);
    chk("if_err", bus.if_err, e_if_err);
    chk("if_rdata", bus.if_rdata, e_if_rdata);
    chk("d_rvalid", bus.d_rvalid, e_d_rv);
    chk("d_err", bus.d_err, e_d_err);
    chk("d_rdata", bus.d_rdata, e_d_rdata);

    e_if_rv = 0; e_if_err = 0; e_d_rv = 0; e_d_err = 0;
    if (own != OWN_NONE) begin
      age++;
      if (ack || age == TO) begin
        e_mem_req = 0;
        if (own == OWN_IF) begin
          e_if_rv = 1;
          e_if_err = !ack;
          e_if_rdata = ack ? bus.mem_rdata : '0;
        end else begin
          e_d_rv = 1;
          e_d_err = !ack;
          e_d_rdata = (ack && !e_mem_we) ? bus.mem_rdata : '0;
        end
        own = OWN_NONE;
      end
    end else if (dg || ig) begin
      own = dg ? OWN_D : OWN_IF;
      age = 0;
      e_mem_req = 1;
      e_mem_we = dg && bus.d_we;
      e_mem_addr = dg ? bus.d_addr : bus.if_addr;
      e_mem_wdata = bus.d_wdata;
      e_mem_wstrb = bus.d_wstrb;
      ack_cd = ($urandom_range(0, 6) == 0) ? 1000 : $urandom_range(1, 4);
      if (ig || !bus.if_req) starve = 0;
      else if (starve < SL) starve++;
    end
    last_ig = ig;
    last_dg = dg;
  endtask

  task automatic cycle_step();
    @(posedge clk);
    #1;
    drive();
    #3;
    check_and_model();
  endtask

  initial begin
    int guard;
    bus.if_req = 0; bus.if_addr = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0;
    bus.d_wdata = '0; bus.d_wstrb = '0;
    bus.mem_ack = 0; bus.mem_rdata = '0;
    model_reset();

    bus.if_req = 1; bus.d_req = 1;
    repeat (2) @(posedge clk);
    #1;
    zero_check("rst");
    bus.if_req = 0; bus.d_req = 0;
    @(negedge clk);
    rst_n = 1;

    if_rate = 50; d_rate = 50;
    repeat (1500) cycle_step();
    if_rate = 95; d_rate = 95;
    repeat (1500) cycle_step();
    if_rate = 30; d_rate = 30;
    repeat (500) cycle_step();

    if_rate = 0; d_rate = 100;
    guard = 0;
    do begin
      cycle_step();
      guard++;
    end while (own != OWN_D && guard < 60);
    @(posedge clk);
    #1;
    bus.mem_ack = 0;
    bus.if_req = 1;
    bus.d_req = 1;
    #1;
    chk("busy_mem_req", bus.mem_req, 1);
    rst_n = 0;
    #1;
    zero_check("midrst");
    @(posedge clk);
    #1;
    zero_check("midrst_hold");
    @(negedge clk);
    rst_n = 1;
    model_reset();
    bus.d_req = 0;
    #1;
    check_and_model();

    if_rate = 60; d_rate = 70;
    repeat (500) cycle_step();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
